// File: rtl/imem_access_arbiter.sv
// Instruction RAM access arbiter: shares a single-port synchronous RAM between
// the IF stage (fetch) and the program loader (write), with a starvation guard,
// one-cycle read response, address range checking and response flush.
module imem_access_arbiter #(
    parameter int unsigned WORD_LEN     = 32,
    parameter int unsigned ADDRESS_LEN  = 32,
    parameter int unsigned MEM_DEPTH    = 64,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    // fetch port
    input  logic                         if_req,
    input  logic [ADDRESS_LEN-1:0]       if_addr,
    output logic                         if_gnt,
    input  logic                         if_flush,
    output logic                         if_valid,
    output logic [WORD_LEN-1:0]          if_instr,
    output logic                         if_fault,
    // loader port
    input  logic                         ld_req,
    input  logic [ADDRESS_LEN-1:0]       ld_addr,
    input  logic [WORD_LEN-1:0]          ld_wdata,
    input  logic                         ld_lock,
    output logic                         ld_gnt,
    // RAM port
    output logic                         mem_en,
    output logic                         mem_we,
    output logic [$clog2(MEM_DEPTH)-1:0] mem_addr,
    output logic [WORD_LEN-1:0]          mem_wdata,
    input  logic [WORD_LEN-1:0]          mem_rdata
);

    localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    // Word indices; the two byte-offset bits are dropped (unaligned aligns down).
    logic [ADDRESS_LEN-3:0] if_word;
    logic [ADDRESS_LEN-3:0] ld_word;
    logic                   if_in_range;
    logic                   ld_in_range;
    logic                   unused_byte_bits;

    assign if_word          = if_addr[ADDRESS_LEN-1:2];
    assign ld_word          = ld_addr[ADDRESS_LEN-1:2];
    assign if_in_range      = (if_word >> IDX_W) == '0;
    assign ld_in_range      = (ld_word >> IDX_W) == '0;
    assign unused_byte_bits = ^{if_addr[1:0], ld_addr[1:0]};

    logic             resp_pending;
    logic             resp_fault;
    logic [CNT_W-1:0] starve_cnt;
    logic [CNT_W-1:0] starve_cnt_next;
    logic             starve_hit;

    assign starve_hit = (starve_cnt == CNT_W'(STARVE_LIMIT));

    // Grant decision; loader has priority unless locked out by the starvation guard.
    always_comb begin
        if_gnt = rst_n & if_req & ~ld_lock & (~ld_req | starve_hit);
        ld_gnt = rst_n & ld_req & ~if_gnt;
    end

    // Starvation counter next state: counts loader wins over a waiting fetch.
    always_comb begin
        starve_cnt_next = starve_cnt;
        if (if_gnt || !if_req) begin
            starve_cnt_next = '0;
        end else if (ld_gnt && !ld_lock && !starve_hit) begin
            starve_cnt_next = starve_cnt + CNT_W'(1);
        end
    end

    // RAM command for the granted requester; out-of-range accesses never enable it.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (if_gnt) begin
            mem_en   = if_in_range;
            mem_addr = if_word[IDX_W-1:0];
        end else if (ld_gnt) begin
            mem_en    = ld_in_range;
            mem_we    = ld_in_range;
            mem_addr  = ld_word[IDX_W-1:0];
            mem_wdata = ld_wdata;
        end
    end

    // Response and starvation state; reset drops any read in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_pending <= 1'b0;
            resp_fault   <= 1'b0;
            starve_cnt   <= '0;
        end else begin
            resp_pending <= if_gnt;
            resp_fault   <= if_gnt & ~if_in_range;
            starve_cnt   <= starve_cnt_next;
        end
    end

    // Fetch response; flush only masks the valid/fault qualifiers of this cycle.
    always_comb begin
        if_valid = resp_pending & ~if_flush;
        if_fault = resp_pending & resp_fault & ~if_flush;
        if_instr = (resp_pending & ~resp_fault) ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_imem_access_arbiter.sv
// Table-driven bench for imem_access_arbiter with a write-first RAM model.
module tb_imem_access_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_flush;
    logic        if_valid;
    logic [31:0] if_instr;
    logic        if_fault;
    logic        ld_req;
    logic [31:0] ld_addr;
    logic [31:0] ld_wdata;
    logic        ld_lock;
    logic        ld_gnt;
    logic        mem_en;
    logic        mem_we;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    imem_access_arbiter #(
        .WORD_LEN    (32),
        .ADDRESS_LEN (32),
        .MEM_DEPTH   (64),
        .STARVE_LIMIT(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_gnt   (if_gnt),
        .if_flush (if_flush),
        .if_valid (if_valid),
        .if_instr (if_instr),
        .if_fault (if_fault),
        .ld_req   (ld_req),
        .ld_addr  (ld_addr),
        .ld_wdata (ld_wdata),
        .ld_lock  (ld_lock),
        .ld_gnt   (ld_gnt),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write-first synchronous single-port RAM.
    logic [31:0] ram [64];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr] <= mem_wdata;
                mem_rdata     <= mem_wdata;
            end else begin
                mem_rdata <= ram[mem_addr];
            end
        end
    end

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        if_flush;
        logic        ld_req;
        logic [31:0] ld_addr;
        logic [31:0] ld_wdata;
        logic        ld_lock;
        logic        e_if_gnt;
        logic        e_ld_gnt;
        logic        e_en;
        logic        e_we;
        logic [5:0]  e_addr;
        logic        e_valid;
        logic        e_fault;
        logic [31:0] e_instr;
    } vec_t;

    vec_t vecs[$];
    int   n_applied;
    int   n_miscompares;

    task automatic add(input logic ir, input logic [31:0] ia, input logic fl,
                       input logic lr, input logic [31:0] la, input logic [31:0] lw,
                       input logic lk, input logic ig, input logic lg, input logic en,
                       input logic we, input logic [5:0] ma, input logic vd,
                       input logic ft, input logic [31:0] ins);
        vec_t v;
        v.if_req = ir; v.if_addr = ia; v.if_flush = fl;
        v.ld_req = lr; v.ld_addr = la; v.ld_wdata = lw; v.ld_lock = lk;
        v.e_if_gnt = ig; v.e_ld_gnt = lg; v.e_en = en; v.e_we = we; v.e_addr = ma;
        v.e_valid = vd; v.e_fault = ft; v.e_instr = ins;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        if_req = 0; if_addr = 0; if_flush = 0;
        ld_req = 0; ld_addr = 0; ld_wdata = 0; ld_lock = 0;
    endtask

    localparam logic [31:0] W0 = 32'hE3A00015;
    localparam logic [31:0] W1 = 32'hE2801000;
    localparam logic [31:0] WN = 32'h7FD423D1;
    localparam logic [31:0] WL = 32'h11112222;

    initial begin
        n_applied = 0;
        n_miscompares = 0;
        for (int i = 0; i < 64; i++) ram[i] = 32'h0;
        ram[0] = W0;
        ram[1] = W1;
        mem_rdata = 32'h0;
        rst_n = 1'b0;
        idle_inputs();

        //   ir ia        fl lr la        lw        lk ig lg en we ma  vd ft instr
        // aligned fetch back-to-back
        add(0, 32'h0,    0, 0, 32'h0,   32'h0,    0, 0, 0, 0, 0, 0,  0, 0, 32'h0);
        add(1, 32'h0,    0, 0, 32'h0,   32'h0,    0, 1, 0, 1, 0, 0,  0, 0, 32'h0);
        add(1, 32'h4,    0, 0, 32'h0,   32'h0,    0, 1, 0, 1, 0, 1,  1, 0, W0);
        add(0, 32'h0,    0, 0, 32'h0,   32'h0,    0, 0, 0, 0, 0, 0,  1, 0, W1);
        // write then read-after-write, aligned and unaligned
        add(0, 32'h0,    0, 1, 32'h8,   WN,       0, 0, 1, 1, 1, 2,  0, 0, 32'h0);
        add(1, 32'h8,    0, 0, 32'h0,   32'h0,    0, 1, 0, 1, 0, 2,  0, 0, 32'h0);
        add(1, 32'hA,    0, 0, 32'h0,   32'h0,    0, 1, 0, 1, 0, 2,  1, 0, WN);
        add(0, 32'h0,    0, 0, 32'h0,   32'h0,    0, 0, 0, 0, 0, 0,  1, 0, WN);
        // out-of-range fetch, then again with flush on the response
        add(1, 32'h100,  0, 0, 32'h0,   32'h0,    0, 1, 0, 0, 0, 0,  0, 0, 32'h0);
        add(0, 32'h0,    0, 0, 32'h0,   32'h0,    0, 0, 0, 0, 0, 0,  1, 1, 32'h0);
        add(1, 32'h100,  0, 0, 32'h0,   32'h0,    0, 1, 0, 0, 0, 0,  0, 0, 32'h0);
        add(0, 32'h0,    1, 0, 32'h0,   32'h0,    0, 0, 0, 0, 0, 0,  0, 0, 32'h0);
        // flush outside a response cycle is ignored
        add(1, 32'h4,    1, 0, 32'h0,   32'h0,    0, 1, 0, 1, 0, 1,  0, 0, 32'h0);
        add(0, 32'h0,    0, 0, 32'h0,   32'h0,    0, 0, 0, 0, 0, 0,  1, 0, W1);
        // in-range flush masks valid; instr stays the raw RAM data
        add(1, 32'h0,    0, 0, 32'h0,   32'h0,    0, 1, 0, 1, 0, 0,  0, 0, 32'h0);
        add(0, 32'h0,    1, 0, 32'h0,   32'h0,    0, 0, 0, 0, 0, 0,  0, 0, W0);
        // out-of-range write granted but dropped
        add(0, 32'h0,    0, 1, 32'h100, 32'hBAD0, 0, 0, 1, 0, 0, 0,  0, 0, 32'h0);
        // starvation: L L L L F L L L L F
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++)
                add(1, 32'h0, 0, 1, 32'h30, WL, 0, 0, 1, 1, 1, 12,
                    (r == 1 && k == 0), 0, (r == 1 && k == 0) ? W0 : 32'h0);
            add(1, 32'h0, 0, 1, 32'h30, WL, 0, 1, 0, 1, 0, 0, 0, 0, 32'h0);
        end
        add(0, 32'h0,    0, 0, 32'h0,   32'h0,    0, 0, 0, 0, 0, 0,  1, 0, W0);
        // lock: loader every cycle, fetch never
        for (int k = 0; k < 10; k++)
            add(1, 32'h0, 0, 1, 32'h30, WL, 1, 0, 1, 1, 1, 12, 0, 0, 32'h0);
        // lock released: loader keeps winning until it goes idle
        add(1, 32'h0,    0, 1, 32'h30,  WL,       0, 0, 1, 1, 1, 12, 0, 0, 32'h0);
        add(1, 32'h0,    0, 1, 32'h30,  WL,       0, 0, 1, 1, 1, 12, 0, 0, 32'h0);
        add(1, 32'h0,    0, 0, 32'h0,   32'h0,    0, 1, 0, 1, 0, 0,  0, 0, 32'h0);
        add(0, 32'h0,    0, 0, 32'h0,   32'h0,    0, 0, 0, 0, 0, 0,  1, 0, W0);
        // lock with only a fetch pending: nothing granted
        add(1, 32'h0,    0, 0, 32'h0,   32'h0,    1, 0, 0, 0, 0, 0,  0, 0, 32'h0);
        add(0, 32'h0,    0, 0, 32'h0,   32'h0,    0, 0, 0, 0, 0, 0,  0, 0, 32'h0);

        // reset-state checks with requests present
        @(negedge clk);
        if_req = 1; ld_req = 1; if_addr = 32'h4;
        #2;
        check("rst if_gnt", {31'h0, if_gnt}, 32'h0);
        check("rst ld_gnt", {31'h0, ld_gnt}, 32'h0);
        check("rst mem_en", {31'h0, mem_en}, 32'h0);
        check("rst mem_we", {31'h0, mem_we}, 32'h0);
        check("rst if_valid", {31'h0, if_valid}, 32'h0);
        check("rst if_instr", if_instr, 32'h0);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            if_req = vecs[i].if_req; if_addr = vecs[i].if_addr; if_flush = vecs[i].if_flush;
            ld_req = vecs[i].ld_req; ld_addr = vecs[i].ld_addr;
            ld_wdata = vecs[i].ld_wdata; ld_lock = vecs[i].ld_lock;
            #2;
            check($sformatf("v%0d if_gnt", i), {31'h0, if_gnt}, {31'h0, vecs[i].e_if_gnt});
            check($sformatf("v%0d ld_gnt", i), {31'h0, ld_gnt}, {31'h0, vecs[i].e_ld_gnt});
            check($sformatf("v%0d mem_en", i), {31'h0, mem_en}, {31'h0, vecs[i].e_en});
            check($sformatf("v%0d mem_we", i), {31'h0, mem_we}, {31'h0, vecs[i].e_we});
            if (vecs[i].e_en)
                check($sformatf("v%0d mem_addr", i), {26'h0, mem_addr}, {26'h0, vecs[i].e_addr});
            if (vecs[i].e_we)
                check($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].ld_wdata);
            check($sformatf("v%0d if_valid", i), {31'h0, if_valid}, {31'h0, vecs[i].e_valid});
            check($sformatf("v%0d if_fault", i), {31'h0, if_fault}, {31'h0, vecs[i].e_fault});
            check($sformatf("v%0d if_instr", i), if_instr, vecs[i].e_instr);
        end

        // fetch granted, then reset pulsed before the cycle ends: response is lost
        @(negedge clk);
        idle_inputs();
        if_req = 1; if_addr = 32'h4;
        #2;
        check("pre-rst if_gnt", {31'h0, if_gnt}, 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        check("in-rst if_gnt", {31'h0, if_gnt}, 32'h0);
        check("in-rst mem_en", {31'h0, mem_en}, 32'h0);
        @(posedge clk);
        #2;
        check("in-rst if_valid", {31'h0, if_valid}, 32'h0);
        check("in-rst if_fault", {31'h0, if_fault}, 32'h0);
        check("in-rst if_instr", if_instr, 32'h0);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            #2;
            check($sformatf("post-rst%0d if_valid", k), {31'h0, if_valid}, 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
        $finish;
    end

endmodule

// File: doc/imem_access_arbiter.md
Name: imem_access_arbiter

Overview:
- Owns the single-port synchronous instruction RAM and shares it between two requesters: the IF stage (read-only fetch) and the program loader/debug port (write-only).
- Arbitrates per cycle with a starvation guard, handles the read latency, range-checks addresses and supports pipeline flush.
- Sits between the IF stage and the instruction RAM macro.

Parameters:
- WORD_LEN, 32, data word width.
- ADDRESS_LEN, 32, byte-address width from both requesters.
- MEM_DEPTH, 64, RAM depth in words; must be a power of two.
- STARVE_LIMIT, 4, consecutive loader grants allowed while a fetch is waiting.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- if_req  in  1  fetch request.
- if_addr  in  ADDRESS_LEN  fetch byte address.
- if_gnt  out  1  fetch accepted this cycle; combinational.
- if_flush  in  1  discard the fetch response due this cycle.
- if_valid  out  1  fetch data valid, one cycle after if_gnt.
- if_instr  out  WORD_LEN  fetched instruction.
- if_fault  out  1  qualifies if_valid: the address was out of range.
- ld_req  in  1  loader write request.
- ld_addr  in  ADDRESS_LEN  loader byte address.
- ld_wdata  in  WORD_LEN  loader write data.
- ld_lock  in  1  loader owns the RAM exclusively; fetch is blocked.
- ld_gnt  out  1  write accepted this cycle; combinational.
- mem_en  out  1  RAM enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  log2(MEM_DEPTH)  RAM word index.
- mem_wdata  out  WORD_LEN  RAM write data.
- mem_rdata  in  WORD_LEN  RAM read data, valid the cycle after a read enable.

Behaviour:
- Word index = addr[ADDRESS_LEN-1:2]. Bits [1:0] are ignored, so an unaligned address is aligned down; there is no fault for misalignment.
- In range means index < MEM_DEPTH; the upper bits must be zero.
- A transfer happens when req and gnt are both high in a cycle. The requester may change its address/data in the next cycle. Throughput is one access per cycle with no bubbles.
- Grant rule, evaluated combinationally each cycle:
  - ld_lock=1: only the loader can be granted; if_gnt=0.
  - Only one requester active: that requester is granted.
  - Both active: the loader wins unless starve_cnt == STARVE_LIMIT, in which case the fetch wins.
- starve_cnt (registered, 0..STARVE_LIMIT):
  - Increments on each cycle where the loader is granted while if_req=1 and ld_lock=0.
  - Clears on any if_gnt, or when if_req=0.
  - Saturates at STARVE_LIMIT.
- Read path:
  - An in-range fetch grant in cycle N drives mem_en=1, mem_we=0, mem_addr=index in cycle N.
  - Cycle N+1: if_valid=1, if_instr=mem_rdata, if_fault=0.
  - If if_flush=1 in cycle N+1, if_valid=0 that cycle. A flush in any other cycle has no effect.
- Out-of-range fetch: no mem_en. Cycle N+1 gives if_valid=1, if_instr=0 (NOP), if_fault=1; flush suppresses it the same way.
- Write path:
  - An in-range loader grant drives mem_en=1, mem_we=1, mem_addr and mem_wdata for that cycle.
  - An out-of-range write is granted and silently dropped (mem_en=0).
- Idle cycles: mem_en=0, mem_we=0. mem_addr and mem_wdata are don't-care but must be driven with no X.
- The RAM is write-first. A write to word A in cycle N followed by a fetch of A in cycle N+1 returns the new data in cycle N+2.
- Registered state: resp_pending, resp_fault, starve_cnt.
- if_instr is mem_rdata gated by resp_pending & ~resp_fault, otherwise 0.
- Reset (async, rst_n=0):
  - resp_pending=0, resp_fault=0, starve_cnt=0.
  - Hence if_valid=0, if_fault=0, if_instr=0.
  - A read in flight when reset asserts is lost; after release no response appears for it.
  - if_gnt, ld_gnt, mem_en and mem_we are forced to 0 while rst_n=0.

Test Plan:
- Preload RAM: word0=32'hE3A00015, word1=32'hE2801000. if_req at addr 0 then 4 on consecutive cycles -> if_gnt on both; if_valid in the following two cycles with E3A00015 then E2801000, if_fault=0.
- Loader writes 32'h7FD423D1 to addr 8 in cycle N, fetch of addr 8 in cycle N+1 -> if_instr=7FD423D1 in cycle N+2. Fetch of addr 0xA (unaligned) returns the same word.
- ld_req and if_req held high continuously, ld_lock=0, STARVE_LIMIT=4 -> grant pattern L,L,L,L,F repeating; starve_cnt returns to 0 after each F.
- ld_lock=1 with both requesting for 10 cycles -> ld_gnt every cycle, if_gnt never. Deassert lock -> if_gnt in the next cycle where the loader is idle or the starvation limit is hit.
- Fetch of byte address 0x100 (index 64 ≥ MEM_DEPTH) -> mem_en=0, then if_valid=1, if_fault=1, if_instr=0. Repeat with if_flush=1 in the response cycle -> if_valid=0.
- Fetch granted in cycle N, rst_n pulsed low mid-cycle N -> if_valid stays 0 through and after reset; outputs are at their reset values while rst_n=0.
